// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the ID/EX hazard controller: FSM states,
// register-zero constant, NOP control bundle and output-pattern constants.
package id_ex_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // ID/EX control fields; a bubble loads all of them as zero.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic if_id_flush;
    } hz_out_t;

    localparam hz_out_t OUT_RUN      = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_bubble: 1'b0, if_id_flush: 1'b0};
    localparam hz_out_t OUT_STALL    = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_bubble: 1'b1, if_id_flush: 1'b0};
    localparam hz_out_t OUT_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_bubble: 1'b1, if_id_flush: 1'b1};
    localparam hz_out_t OUT_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_bubble: 1'b1, if_id_flush: 1'b1};

endpackage

// File: rtl/id_ex_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use / redirect hazard controller driving PC, IF/ID and ID/EX write side,
// with multi-cycle stall/flush sequencing and saturating performance counters.
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRegRs,
    input  logic [4:0]       idRegRt,
    input  logic             idUsesRt,
    input  logic             exMemRead,
    input  logic [4:0]       exRegRt,
    input  logic             branchTaken,
    input  logic             jumpTaken,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExBubble,
    output logic             ifIdFlush,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCycles
);

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    hz_out_t    out;
    logic       load_use;
    logic       redirect;

    assign load_use = exMemRead && (exRegRt != REG_ZERO) &&
                      ((exRegRt == idRegRs) || (idUsesRt && (exRegRt == idRegRt)));
    assign redirect = branchTaken || jumpTaken;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out     = OUT_RUN;
        if (reset) begin
            out     = OUT_RESET;
            state_d = ST_RUN;
            cnt_d   = 4'd0;
        end else if (redirect) begin
            // Redirect wins in every state and (re)starts the flush window.
            out   = OUT_REDIRECT;
            cnt_d = FLUSH_RELOAD;
            state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        out     = OUT_STALL;
                        cnt_d   = STALL_RELOAD;
                        state_d = (LOAD_STALL > 1) ? ST_STALL : ST_RUN;
                    end
                end
                ST_STALL: begin
                    out   = OUT_STALL;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    out   = OUT_REDIRECT;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pcWrite    = out.pc_write;
    assign ifIdWrite  = out.if_id_write;
    assign idExBubble = out.id_ex_bubble;
    assign ifIdFlush  = out.if_id_flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~out.pc_write),
        .count (stallCycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out.if_id_flush),
        .count (flushCycles)
    );

endmodule
